// File: rtl/pipeline_fetch_unit.sv
// pipeline_fetch_unit: instruction fetch/sequencer feeding the 4-stage arithmetic pipeline.
// Ports: clk, rst_n (async active-low); prog_we/prog_addr/prog_data program-load port (IDLE only);
// prog_len words to run (sampled on start, saturated to DEPTH); start, stop, stall control;
// A/B/opcode/valid registered issue outputs; pc next fetch address; busy (RUN); done (1-cycle pulse).
// Optional PIPELINE_FETCH_LOOP_EN: end of program wraps pc to 0 with one bubble instead of finishing.
module pipeline_fetch_unit #(
  parameter int DEPTH = 16,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [17:0]   prog_data,
  input  logic [AW:0]   prog_len,
  input  logic          start,
  input  logic          stop,
  input  logic          stall,
  output logic [7:0]    A,
  output logic [7:0]    B,
  output logic [1:0]    opcode,
  output logic          valid,
  output logic [AW:0]   pc,
  output logic          busy,
  output logic          done
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  state_t state;
  logic [17:0] mem [DEPTH];
  logic [AW:0] len_q;
  logic [17:0] word;
  logic at_end, halt, end_run, go_done;
  assign word = mem[pc[AW-1:0]];
  assign at_end = pc == len_q;
  assign halt = word[17:16] == 2'b11;
`ifdef PIPELINE_FETCH_LOOP_EN
  // an empty program still finishes immediately; otherwise the end wraps around
  assign end_run = at_end && (len_q == '0);
`else
  assign end_run = at_end;
`endif
  // the end-of-program check outranks HALT, so a HALT word just past the end is never seen
  assign go_done = end_run || (!at_end && halt);
  always_ff @(posedge clk)
    if (state == IDLE && prog_we) mem[prog_addr] <= prog_data;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      A <= '0;
      B <= '0;
      opcode <= '0;
      valid <= 1'b0;
      pc <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      len_q <= '0;
    end else
      case (state)
        IDLE:
          if (start) begin
            len_q <= prog_len > DEPTH_W ? DEPTH_W : prog_len;
            pc <= '0;
            busy <= 1'b1;
            state <= RUN;
          end
        RUN:
          if (stop) begin
            valid <= 1'b0;
            busy <= 1'b0;
            state <= IDLE;
          end else if (!stall) begin
            if (go_done) begin
              valid <= 1'b0;
              busy <= 1'b0;
              done <= 1'b1;
              state <= DONE;
            end else if (at_end) begin
              pc <= '0;
              valid <= 1'b0;
            end else begin
              {opcode, A, B} <= word;
              valid <= 1'b1;
              pc <= pc + 1'b1;
            end
          end
        default: begin
          done <= 1'b0;
          state <= IDLE;
        end
      endcase
endmodule

// File: tb/tb_pipeline_fetch_unit.sv
// tb_pipeline_fetch_unit: directed self-checking bench for pipeline_fetch_unit.
module tb_pipeline_fetch_unit;
  logic clk = 1'b0, rst_n = 1'b0;
  logic prog_we = 1'b0, start = 1'b0, stop = 1'b0, stall = 1'b0;
  logic [3:0] prog_addr = '0;
  logic [17:0] prog_data = '0;
  logic [4:0] prog_len = '0;
  logic [7:0] A, B;
  logic [1:0] opcode;
  logic valid, busy, done;
  logic [4:0] pc;
  int checks = 0, errors = 0;
  logic [17:0] w [4];

  pipeline_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .prog_len(prog_len), .start(start), .stop(stop), .stall(stall), .A(A), .B(B), .opcode(opcode),
    .valid(valid), .pc(pc), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [3:0] a, input logic [17:0] d);
    prog_we = 1'b1;
    prog_addr = a;
    prog_data = d;
    tick();
    prog_we = 1'b0;
  endtask

  task automatic go(input logic [4:0] len);
    prog_len = len;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({A, B, opcode, valid, pc, busy, done} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got A=%h B=%h op=%b v=%b pc=%0d busy=%b done=%b want all 0", A, B, opcode, valid, pc, busy, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    w[0] = {2'b00, 8'h05, 8'h03};
    w[1] = {2'b01, 8'h09, 8'h04};
    w[2] = {2'b10, 8'h07, 8'h00};
    for (int i = 0; i < 3; i++) load(4'(i), w[i]);
    go(5'd3);
    checks++;
    if (busy !== 1'b1 || valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_start: busy=%b valid=%b want busy=1 valid=0", busy, valid);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (valid !== 1'b1 || {opcode, A, B} !== w[i] || pc !== 5'(i + 1)) begin
        errors++;
        $display("FAIL basic_issue%0d: v=%b word=%h pc=%0d want v=1 word=%h pc=%0d", i, valid, {opcode, A, B}, pc, w[i], i + 1);
      end
    end
    tick();
    checks++;
    if (done !== 1'b1 || valid !== 1'b0 || pc !== 5'd3) begin
      errors++;
      $display("FAIL basic_done: done=%b v=%b pc=%0d want done=1 v=0 pc=3", done, valid, pc);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || pc !== 5'd3) begin
      errors++;
      $display("FAIL basic_idle: done=%b busy=%b pc=%0d want done=0 busy=0 pc=3", done, busy, pc);
    end
  endtask

  task automatic test_halt();
    load(4'd0, {2'b00, 8'h01, 8'h01});
    load(4'd1, {2'b11, 8'h00, 8'h00});
    load(4'd2, {2'b00, 8'h02, 8'h02});
    go(5'd3);
    tick();
    checks++;
    if (valid !== 1'b1 || {opcode, A, B} !== {2'b00, 8'h01, 8'h01}) begin
      errors++;
      $display("FAIL halt_issue0: v=%b word=%h want v=1 word=00101", valid, {opcode, A, B});
    end
    tick();
    checks++;
    if (done !== 1'b1 || valid !== 1'b0 || pc !== 5'd1) begin
      errors++;
      $display("FAIL halt_done: done=%b v=%b pc=%0d want done=1 v=0 pc=1", done, valid, pc);
    end
    tick();
    checks++;
    if (done !== 1'b0 || valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL halt_idle: done=%b v=%b busy=%b want 0 0 0", done, valid, busy);
    end
  endtask

  task automatic test_stall();
    logic [17:0] exp [7];
    logic [4:0] epc [7];
    w[0] = {2'b00, 8'h11, 8'h12};
    w[1] = {2'b01, 8'h21, 8'h22};
    w[2] = {2'b10, 8'h31, 8'h32};
    w[3] = {2'b00, 8'h41, 8'h42};
    for (int i = 0; i < 4; i++) load(4'(i), w[i]);
    exp = '{w[0], w[1], w[1], w[1], w[2], w[3], 18'h0};
    epc = '{5'd1, 5'd2, 5'd2, 5'd2, 5'd3, 5'd4, 5'd4};
    go(5'd4);
    for (int i = 0; i < 6; i++) begin
      stall = (i == 2 || i == 3);
      tick();
      checks++;
      if (valid !== 1'b1 || {opcode, A, B} !== exp[i] || pc !== epc[i]) begin
        errors++;
        $display("FAIL stall_cycle%0d: v=%b word=%h pc=%0d want v=1 word=%h pc=%0d", i, valid, {opcode, A, B}, pc, exp[i], epc[i]);
      end
    end
    stall = 1'b0;
    tick();
    checks++;
    if (done !== 1'b1 || valid !== 1'b0 || pc !== 5'd4) begin
      errors++;
      $display("FAIL stall_done: done=%b v=%b pc=%0d want done=1 v=0 pc=4", done, valid, pc);
    end
    tick();
  endtask

  task automatic test_stop();
    go(5'd4);
    tick();
    tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checks++;
    if (valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || pc !== 5'd2) begin
      errors++;
      $display("FAIL stop_abort: v=%b done=%b busy=%b pc=%0d want 0 0 0 pc=2", valid, done, busy, pc);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL stop_no_done: done=%b busy=%b want 0 0", done, busy);
    end
  endtask

  task automatic test_reset_midrun();
    go(5'd4);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({A, B, opcode, valid, pc, busy, done} !== '0) begin
      errors++;
      $display("FAIL async_reset: A=%h B=%h op=%b v=%b pc=%0d busy=%b done=%b want all 0", A, B, opcode, valid, pc, busy, done);
    end
    #1;
    rst_n = 1'b1;
    tick();
    go(5'd4);
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (valid !== 1'b1 || {opcode, A, B} !== w[i]) begin
        errors++;
        $display("FAIL rerun_issue%0d: v=%b word=%h want v=1 word=%h", i, valid, {opcode, A, B}, w[i]);
      end
    end
    tick();
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL rerun_done: done=%b want 1", done);
    end
    tick();
  endtask

  task automatic test_len0();
    go(5'd0);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL len0_busy: busy=%b want 1", busy);
    end
    tick();
    checks++;
    if (done !== 1'b1 || valid !== 1'b0 || pc !== 5'd0) begin
      errors++;
      $display("FAIL len0_done: done=%b v=%b pc=%0d want done=1 v=0 pc=0", done, valid, pc);
    end
    tick();
  endtask

  task automatic test_full(input logic [4:0] len, input logic write_during_run);
    for (int i = 0; i < 16; i++) load(4'(i), {2'b00, 8'(i), 8'(i)});
    go(len);
    for (int i = 0; i < 16; i++) begin
      prog_we = write_during_run && i == 0;
      prog_addr = 4'd15;
      prog_data = {2'b11, 8'hff, 8'hff};
      tick();
      prog_we = 1'b0;
      checks++;
      if (valid !== 1'b1 || {opcode, A, B} !== {2'b00, 8'(i), 8'(i)} || pc !== 5'(i + 1)) begin
        errors++;
        $display("FAIL full%0d_issue%0d: v=%b word=%h pc=%0d want v=1 word=%h pc=%0d", len, i, valid, {opcode, A, B}, pc, {2'b00, 8'(i), 8'(i)}, i + 1);
      end
    end
    tick();
    checks++;
    if (done !== 1'b1 || pc !== 5'd16) begin
      errors++;
      $display("FAIL full%0d_done: done=%b pc=%0d want done=1 pc=16", len, done, pc);
    end
    tick();
  endtask

  task automatic test_loop();
    logic [17:0] exp [6];
    logic [2:0] ev;
    load(4'd0, {2'b00, 8'h11, 8'h22});
    load(4'd1, {2'b01, 8'h33, 8'h44});
    exp = '{{2'b00, 8'h11, 8'h22}, {2'b01, 8'h33, 8'h44}, 18'h0, {2'b00, 8'h11, 8'h22}, {2'b01, 8'h33, 8'h44}, 18'h0};
    go(5'd2);
    for (int i = 0; i < 6; i++) begin
      tick();
      ev = (i == 2 || i == 5) ? 3'd0 : 3'd1;
      checks++;
      if (valid !== ev[0] || (ev[0] && {opcode, A, B} !== exp[i]) || done !== 1'b0) begin
        errors++;
        $display("FAIL loop_cycle%0d: v=%b word=%h done=%b want v=%b word=%h done=0", i, valid, {opcode, A, B}, done, ev[0], exp[i]);
      end
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checks++;
    if (valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL loop_stop: v=%b busy=%b done=%b want 0 0 0", valid, busy, done);
    end
    load(4'd1, {2'b11, 8'h00, 8'h00});
    go(5'd2);
    tick();
    checks++;
    if (valid !== 1'b1 || {opcode, A, B} !== exp[0]) begin
      errors++;
      $display("FAIL loop_halt_w0: v=%b word=%h want v=1 word=%h", valid, {opcode, A, B}, exp[0]);
    end
    tick();
    checks++;
    if (done !== 1'b1 || valid !== 1'b0) begin
      errors++;
      $display("FAIL loop_halt_done: done=%b v=%b want done=1 v=0", done, valid);
    end
    tick();
  endtask

  initial begin
    test_reset();
`ifdef PIPELINE_FETCH_LOOP_EN
    test_len0();
    test_loop();
`else
    test_basic();
    test_halt();
    test_stall();
    test_stop();
    test_reset_midrun();
    test_len0();
    test_full(5'd16, 1'b1);
    test_full(5'd20, 1'b0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipeline_fetch_unit.md
# pipeline_fetch_unit

Instruction fetch and sequencer stage that feeds the 4-stage arithmetic pipeline. It holds a small program memory of packed {opcode, A, B} words, loaded through a write port while idle. On `start` it issues one instruction per clock on registered `A`/`B`/`opcode` outputs with a `valid` qualifier, honouring `stall`, `stop` and an in-band HALT opcode. Its outputs connect directly to the pipeline's `A`, `B` and `opcode` inputs.

## Interface
- `DEPTH`, 16: program memory words.
- `AW`, 4: address width; must satisfy 2^AW = DEPTH.

- `clk` input 1: single clock; all state changes on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset. Asserts immediately; deasserts synchronously to `clk`.
- `prog_we` input 1: program write strobe. Accepted only in IDLE.
- `prog_addr` input AW: write address.
- `prog_data` input 18: word to write, packed as {opcode[17:16], A[15:8], B[7:0]}.
- `prog_len` input AW+1: number of words to run, 0..DEPTH. Sampled on `start`.
- `start` input 1: begin execution. Accepted only in IDLE.
- `stop` input 1: abort execution.
- `stall` input 1: hold the fetch stage.
- `A` output 8: issued operand A.
- `B` output 8: issued operand B.
- `opcode` output 2: issued opcode.
- `valid` output 1: `A`/`B`/`opcode` carry a real instruction.
- `pc` output AW+1: address of the next word to fetch.
- `busy` output 1: high in RUN.
- `done` output 1: one-cycle pulse at end of program.

## Operation
- State machine has three states: IDLE, RUN, DONE.
- **Reset:** state IDLE. `A`, `B`, `opcode`, `valid`, `pc`, `busy`, `done` all reset to 0. Memory contents are not reset.
- **IDLE:**
  - `prog_we` writes `mem[prog_addr] <= prog_data`.
  - `start` latches `prog_len` into `len_q`, sets `pc <= 0`, and moves to RUN.
  - If `start` and `prog_we` are both high, both take effect.
- **RUN, `stall` = 0.** Each edge evaluates these rules in priority order:
  1. `stop` = 1: go to IDLE, `valid <= 0`, no `done`.
  2. `pc == len_q`: end of program. Go to DONE, `valid <= 0` (LOOP_EN changes this rule; see Configuration).
  3. `mem[pc].opcode == 2'b11` (HALT): the word is not issued. Go to DONE, `valid <= 0`.
  4. Otherwise: `{opcode, A, B} <= mem[pc]`, `valid <= 1`, `pc <= pc + 1`.
- **RUN, `stall` = 1:**
  - `A`, `B`, `opcode`, `valid` and `pc` hold.
  - `stop` still takes priority and aborts.
- **DONE:** `done` = 1 for exactly this one cycle, `valid` = 0, `pc` holds. Return to IDLE on the next edge.
- `prog_we` and `start` are ignored outside IDLE.
- `prog_len` values above DEPTH are saturated to DEPTH when latched.

## Timing
- `start` is sampled at edge k. The first instruction is valid after edge k+1; each subsequent unstalled edge issues one more.
- With no stalls, N words issue on edges k+1..k+N. Edge k+N+1 enters DONE, so `done` is high for the cycle following that edge. `busy` is high from after edge k through edge k+N+1.
- `prog_len` = 0: edge k+1 enters DONE directly; no instruction is issued.
- Memory read is combinational from `pc`; outputs are registered, giving zero bubbles between consecutive issues.
- Stall-to-output latency is 0: outputs are frozen on the same edge that samples `stall` high.
- `rst_n` asserted mid-run clears outputs immediately and returns to IDLE. The program memory is retained.

## Configuration
- `PIPELINE_FETCH_LOOP_EN`, defined:
  - Reaching `pc == len_q` in RUN does not end the program. It sets `pc <= 0` and `valid <= 0`, giving a single bubble, and execution continues.
  - The program ends only via HALT (to DONE) or `stop` (to IDLE).
  - `prog_len` = 0 is still handled as immediate DONE.
- Undefined: end of program goes to DONE as described under Operation.

## Test plan
- **Basic run:** load {00,05,03}, {01,09,04}, {10,07,00} at addresses 0..2, `prog_len` = 3, pulse `start` → `valid` high for 3 consecutive cycles carrying those words in order, then `done` pulses once, then `busy` = 0 and `pc` = 3.
- **HALT:** load {00,01,01}, {11,xx,xx}, {00,02,02}, `prog_len` = 3 → exactly one instruction issued, `done` pulses, and word 2 never appears.
- **Stall:** 4-word program with `stall` high for 2 cycles after the second issue → the second word is held for 3 cycles total, `pc` holds at 2, and all 4 words issue with none lost or duplicated.
- **Stop and reset:** assert `stop` after 2 issues → `valid` = 0 next cycle, no `done`, state IDLE. Separately, assert `rst_n` low mid-run → all outputs are 0 asynchronously; a subsequent `start` reruns the retained program correctly.
- **Boundaries:** `prog_len` = 0 → `done` on the cycle after `start` with no `valid`. `prog_len` = 16 with all words 00 → 16 issues and `pc` reaches 16. `prog_we` during RUN → memory unchanged.
- **Loop mode (`PIPELINE_FETCH_LOOP_EN`):** 2-word program → issue pattern w0, w1, bubble, w0, w1, … until `stop`. Placing HALT at word 1 → w0 is issued, then `done`.
